ppa_rr_arbiter: RTL and testbench
=================================

Name: ppa_rr_arbiter

Overview:
Parametrised round-robin bus arbiter built on a parallel-prefix priority core. Supersedes the fixed 8-bit combinational arbiter: N requesters, a registered one-hot grant, an internally rotating priority pointer, burst hold with a bounded tenure, and a software pointer load. Sits between bus masters and the shared bus mux; o_grant drives the mux select directly.

Parameters:
N, 8, number of requesters (2..32)
MAX_HOLD, 4, max consecutive cycles one grant may be held before forced rotation (>=1; 1 = rotate every cycle)
RST_PRIOR, 1 (bit 0 set), one-hot reset value of the priority pointer; must be one-hot and N bits wide

Ports:
i_bus_clk  input  1  clock, all state on rising edge
i_bus_rstn  input  1  asynchronous active-low reset
i_req  input  N  request vector, level-sensitive
i_prior  input  N  one-hot priority pointer load value
i_prior_ld  input  1  load strobe for i_prior
o_grant  output  N  registered one-hot grant, or all zeros
o_grant_idx  output  $clog2(N)  binary index of o_grant; 0 when no grant
o_ag  output  1  registered any-grant, equals |o_grant

Behaviour:
- Reset is asynchronous active-low: i_bus_rstn low forces o_grant=0, o_ag=0, o_grant_idx=0, pointer=RST_PRIOR, hold_cnt=0, state=IDLE, immediately and independent of clock. Reset asserted mid-grant drops the grant at once.
- Pointer: one-hot; the set bit is highest priority, priority decreasing toward higher indices and wrapping from N-1 to 0.
- Pick function: parallel-prefix thermometer mask of requests at or above the pointer; if the masked vector is non-zero, grant its lowest set bit, else the lowest set bit of unmasked i_req. Purely combinational, one cycle.
- Latency: a request sampled at edge t is granted at output after edge t, one cycle later. No combinational path from i_req to o_grant.
- FSM IDLE: no grant. If any i_req bit is set, go to GRANT, o_grant=pick, hold_cnt=1. Otherwise stay.
- FSM GRANT, grantee g:
  - Release when i_req[g]=0, or when hold_cnt==MAX_HOLD.
  - On release, pointer=rotl(o_grant,1).
  - Re-arbitrate on the same edge using the new pointer. There is no idle bubble. If a grant results, hold_cnt=1; otherwise go to IDLE with o_grant=0.
  - A forced release with g as the only requester re-grants g with hold_cnt=1, so o_ag stays 1.
  - With no release, keep o_grant and increment hold_cnt.
- Pointer load: i_prior_ld=1 with one-hot i_prior stores i_prior as the pending pointer.
  - In IDLE it is used by an arbitration on the same edge.
  - In GRANT it replaces the rotate result at the next release.
  - A non-one-hot i_prior, including zero, is ignored.
  - A load and a release on the same edge: the load wins.
- Grant may change only when the current grantee drops its request or its tenure expires. It never preempts early because a higher-priority request arrives.
- hold_cnt width is $clog2(MAX_HOLD+1) and never exceeds MAX_HOLD.

Optional Feature:
Macro ARB_MASK_EN.
- Defined: adds port i_mask input N. Requests are qualified as i_req & i_mask before the pick function. Clearing i_mask[g] for the current grantee acts as a request drop: release at the next edge and rotate.
- Not defined: port absent, mask treated as all ones, logic identical otherwise.

Test Plan:
1. Reset with i_bus_rstn=0 and i_req=8'h48 for 4 cycles -> o_grant=0, o_ag=0, idx=0. Assert reset mid-grant -> o_grant=0 asynchronously, before the next edge.
2. After reset (pointer=8'h01), i_req=8'h48 held -> o_grant=8'h08, idx=3 for 4 cycles. 5th cycle o_grant=8'h40, idx=6. Stays 8'h40 for 4 cycles, then 8'h08 again.
3. i_req=8'h41 from IDLE, pointer 8'h01 -> o_grant=8'h01. Then i_req=8'h40 -> o_grant=8'h40 on the very next edge, with o_ag never 0.
4. Only i_req=8'h80 held 10 cycles -> o_grant=8'h80 and o_ag=1 on every cycle, including the forced-release edges at cycles 4 and 8.
5. In IDLE, i_prior_ld=1 with i_prior=8'h10 and i_req=8'h29 -> o_grant=8'h20, idx=5. Repeat with i_prior=8'h11 -> load ignored, pointer unchanged.
6. ARB_MASK_EN: i_req=8'h09, i_mask=8'hFE -> o_grant=8'h08. Clear i_mask[3] -> grant drops at the next edge, then o_grant=0 and state IDLE.

Source files
------------

// File: rtl/ppa_rr_arbiter.sv
// ppa_rr_arbiter
// Round-robin bus arbiter built around a parallel-prefix priority pick.
// The grant is registered and one-hot, and it drives the shared bus mux select directly.
// A grantee keeps the bus until it drops its request or its tenure reaches MAX_HOLD cycles.
// On release, priority rotates to the requester just above the old grantee.
// Software can preload the priority pointer through i_prior / i_prior_ld.
//
// Optional build macro: ARB_MASK_EN
//   When defined, the i_mask port is added and requests are qualified as i_req & i_mask.
//   When undefined, the mask is treated as all ones.
//
// Ports:
//   i_bus_clk    clock, all state updates on the rising edge
//   i_bus_rstn   asynchronous active-low reset
//   i_req        [N] level-sensitive request vector
//   i_prior      [N] one-hot priority pointer load value
//   i_prior_ld   load strobe for i_prior; ignored unless i_prior is one-hot
//   i_mask       [N] request qualifier (only when ARB_MASK_EN is defined)
//   o_grant      [N] registered one-hot grant, or all zeros
//   o_grant_idx  [$clog2(N)] binary index of o_grant, 0 when there is no grant
//   o_ag         registered any-grant flag, equal to |o_grant
module ppa_rr_arbiter #(
  parameter int N = 8,
  parameter int MAX_HOLD = 4,
  parameter logic [N-1:0] RST_PRIOR = {{(N-1){1'b0}}, 1'b1}
) (
  input  logic                 i_bus_clk,
  input  logic                 i_bus_rstn,
  input  logic [N-1:0]         i_req,
  input  logic [N-1:0]         i_prior,
  input  logic                 i_prior_ld,
`ifdef ARB_MASK_EN
  input  logic [N-1:0]         i_mask,
`endif
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_grant_idx,
  output logic                 o_ag
);

  localparam int IDXW = $clog2(N);
  localparam int HCW  = $clog2(MAX_HOLD + 1);
  localparam logic [N-1:0]   ONE      = {{(N-1){1'b0}}, 1'b1};
  localparam logic [HCW-1:0] HOLD_ONE = HCW'(1);
  localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]     state;
  logic [N-1:0]   ptr;
  logic           ld_pend;
  logic [HCW-1:0] hold_cnt;

  logic [N-1:0]    req_q;
  logic            prior_ok;
  logic            release_now;
  logic            arb_now;
  logic [N-1:0]    arb_ptr;
  logic [N-1:0]    masked;
  logic [N-1:0]    pick;
  logic [IDXW-1:0] pick_idx;

  // Isolate the lowest set bit (two's-complement trick).
  function automatic logic [N-1:0] low_bit(input logic [N-1:0] v);
    return v & (~v + ONE);
  endfunction

  // Log-depth prefix OR turns the one-hot pointer into a thermometer.
  // The result covers every bit at or above the pointer.
  function automatic logic [N-1:0] therm_mask(input logic [N-1:0] p);
    logic [N-1:0] t;
    t = p;
    for (int s = 1; s < N; s = s * 2) begin
      t = t | (t << s);
    end
    return t;
  endfunction

  // Release and arbitration decisions, plus the pointer used for this edge.
  // A valid load takes precedence over both the rotate and a load stored earlier.
  // A load stored during a tenure (ld_pend) suppresses the rotate at release.
  always_comb begin
`ifdef ARB_MASK_EN
    req_q = i_req & i_mask;
`else
    req_q = i_req;
`endif
    prior_ok    = i_prior_ld && (i_prior != '0) && ((i_prior & (i_prior - ONE)) == '0);
    release_now = (state == GRANT) && (((req_q & o_grant) == '0) || (hold_cnt == HOLD_MAX));
    arb_now     = (state == IDLE) || release_now;

    if (prior_ok) begin
      arb_ptr = i_prior;
    end else if (release_now && !ld_pend) begin
      arb_ptr = {o_grant[N-2:0], o_grant[N-1]};
    end else begin
      arb_ptr = ptr;
    end

    masked = req_q & therm_mask(arb_ptr);
    pick   = (masked != '0) ? low_bit(masked) : low_bit(req_q);

    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) begin
        pick_idx = IDXW'(i);
      end
    end
  end

  // Grant FSM.
  // On an arbitration edge (IDLE, or a release) it commits the pointer and either grants or falls back to IDLE.
  // Otherwise the tenure counter advances, and any load is parked until the release.
  always_ff @(posedge i_bus_clk or negedge i_bus_rstn) begin
    if (!i_bus_rstn) begin
      state       <= IDLE;
      ptr         <= RST_PRIOR;
      ld_pend     <= 1'b0;
      hold_cnt    <= '0;
      o_grant     <= '0;
      o_grant_idx <= '0;
      o_ag        <= 1'b0;
    end else if (arb_now) begin
      ptr     <= arb_ptr;
      ld_pend <= 1'b0;
      if (req_q != '0) begin
        state       <= GRANT;
        o_grant     <= pick;
        o_grant_idx <= pick_idx;
        o_ag        <= 1'b1;
        hold_cnt    <= HOLD_ONE;
      end else begin
        state       <= IDLE;
        o_grant     <= '0;
        o_grant_idx <= '0;
        o_ag        <= 1'b0;
        hold_cnt    <= '0;
      end
    end else begin
      hold_cnt <= hold_cnt + HOLD_ONE;
      if (prior_ok) begin
        ptr     <= i_prior;
        ld_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ppa_rr_arbiter.sv
// tb_ppa_rr_arbiter
// Scoreboard bench for ppa_rr_arbiter with N=8 and MAX_HOLD=4.
// The stimulus process drives one vector per cycle.
// For each vector it queues the hand-computed grant expected after the next rising edge.
// A monitor on the falling edge pops those entries and compares them against o_grant, o_grant_idx and o_ag.
module tb_ppa_rr_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] req;
  logic [7:0] prior;
  logic       prior_ld;
  logic [7:0] mask;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       ag;

  int cyc = 0;
  int checks_total = 0;
  int checks_passed = 0;

  typedef struct {
    int         cyc;
    logic [7:0] grant;
    logic [2:0] idx;
    int         id;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  ppa_rr_arbiter #(.N(8), .MAX_HOLD(4), .RST_PRIOR(8'h01)) dut (
    .i_bus_clk   (clk),
    .i_bus_rstn  (rstn),
    .i_req       (req),
    .i_prior     (prior),
    .i_prior_ld  (prior_ld),
`ifdef ARB_MASK_EN
    .i_mask      (mask),
`endif
    .o_grant     (grant),
    .o_grant_idx (grant_idx),
    .o_ag        (ag)
  );

  // One comparison of all three outputs against an expected grant.
  // The expected any-grant flag is derived from the expected grant vector.
  task automatic checkOutput(input int id, input logic [7:0] exp_grant, input logic [2:0] exp_idx);
    logic exp_ag;
    exp_ag = |exp_grant;
    checks_total++;
    if (grant === exp_grant && grant_idx === exp_idx && ag === exp_ag) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL step%0d cyc%0d: got grant=%h idx=%0d ag=%b, want grant=%h idx=%0d ag=%b",
               id, cyc, grant, grant_idx, ag, exp_grant, exp_idx, exp_ag);
    end
  endtask

  // Drive a vector now (just after a falling edge) and queue the expected result after the next rising edge.
  // Then move on to the next falling edge.
  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] p, input logic ld,
                               input logic [7:0] exp_grant, input logic [2:0] exp_idx, input int id);
    exp_t e;
    req      = r;
    prior    = p;
    prior_ld = ld;
    e.cyc    = cyc + 1;
    e.grant  = exp_grant;
    e.idx    = exp_idx;
    e.id     = id;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // Monitor: the DUT presents a registered grant every cycle.
  // Any entries due by now are checked.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput(e.id, e.grant, e.idx);
    end
  end

  initial begin
    rstn     = 1'b0;
    req      = 8'h48;
    prior    = 8'h00;
    prior_ld = 1'b0;
    mask     = 8'hFF;
    @(negedge clk);
    #1;

    // Reset held with requests pending: no grant.
    for (int i = 0; i < 4; i++) applyStimulus(8'h48, 8'h00, 1'b0, 8'h00, 3'd0, 1);
    rstn = 1'b1;

    // Pointer 01, requests 3 and 6: tenure of 4, rotate, and wrap back to 3.
    for (int i = 0; i < 12; i++) begin
      if (i >= 4 && i < 8) applyStimulus(8'h48, 8'h00, 1'b0, 8'h40, 3'd6, 2);
      else                 applyStimulus(8'h48, 8'h00, 1'b0, 8'h08, 3'd3, 2);
    end
    applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 2);

    // Load pointer 01 in IDLE, then hand over from 0 to 6 without a bubble.
    applyStimulus(8'h41, 8'h01, 1'b1, 8'h01, 3'd0, 3);
    applyStimulus(8'h40, 8'h00, 1'b0, 8'h40, 3'd6, 3);
    applyStimulus(8'h40, 8'h00, 1'b0, 8'h40, 3'd6, 3);

    // Sole requester 7 survives forced releases.
    for (int i = 0; i < 10; i++) applyStimulus(8'h80, 8'h00, 1'b0, 8'h80, 3'd7, 4);
    applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 4);

    // Pointer load used on the same edge in IDLE.
    applyStimulus(8'h29, 8'h10, 1'b1, 8'h20, 3'd5, 5);
    applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 5);
    // A non-one-hot load (11) is ignored: the rotated pointer 40 wraps the grant to bit 0.
    applyStimulus(8'h29, 8'h11, 1'b1, 8'h01, 3'd0, 5);
    applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 5);
    // A non-one-hot load (30) is ignored: pointer 02 gives bit 3, not bit 5.
    applyStimulus(8'h29, 8'h30, 1'b1, 8'h08, 3'd3, 5);
    // A load during a tenure does not preempt the grant; it is used at the release.
    applyStimulus(8'h29, 8'h80, 1'b1, 8'h08, 3'd3, 7);
    applyStimulus(8'h21, 8'h00, 1'b0, 8'h01, 3'd0, 7);
    // A load and a release on the same edge: the load wins.
    applyStimulus(8'h28, 8'h20, 1'b1, 8'h20, 3'd5, 7);
    applyStimulus(8'h20, 8'h00, 1'b0, 8'h20, 3'd5, 7);

    // Asynchronous reset mid-grant drops the grant before any edge.
    rstn = 1'b0;
    #1;
    checkOutput(8, 8'h00, 3'd0);
    applyStimulus(8'h20, 8'h00, 1'b0, 8'h00, 3'd0, 8);
    rstn = 1'b1;

`ifdef ARB_MASK_EN
    // Masked requester 0 is skipped; masking the grantee releases it.
    mask = 8'hFE;
    applyStimulus(8'h09, 8'h00, 1'b0, 8'h08, 3'd3, 6);
    mask = 8'hF6;
    applyStimulus(8'h09, 8'h00, 1'b0, 8'h00, 3'd0, 6);
    mask = 8'hFF;
`else
    applyStimulus(8'h09, 8'h00, 1'b0, 8'h01, 3'd0, 6);
    applyStimulus(8'h08, 8'h00, 1'b0, 8'h08, 3'd3, 6);
`endif
    applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 9);

    // Bounded drain of anything still queued.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks_total++;
      $display("[TB] FAIL drain: %0d entries left, want 0", sb.size());
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
